// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register: captures a word on load and emits it
// MSB-first, one bit per enabled clock, with busy/done status flags.
module piso_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             shift_enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    LOADED
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data, data_next;
  logic [CW-1:0]    count, count_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      data      <= '0;
      count     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data      <= data_next;
      count     <= count_next;
      done_reg  <= done_next;
    end
  end

  // Load wins over shift; a load while LOADED simply restarts the word.
  always_comb begin
    state_next = state_reg;
    data_next  = data;
    count_next = count;
    done_next  = done_reg;
    if (load) begin
      state_next = LOADED;
      data_next  = data_in;
      count_next = CW'(WIDTH);
      done_next  = 1'b0;
    end else if (shift_enable && state_reg == LOADED) begin
      data_next  = {data[WIDTH-2:0], 1'b0};
      count_next = count - CW'(1);
      if (count == CW'(1)) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  assign serial_out = data[WIDTH-1];
  assign busy       = (state_reg == LOADED);
  assign done       = done_reg;

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench for piso_shift_register: directed test-plan steps followed
// by randomized load/shift traffic compared against a word/bit-index model.
module tb_piso_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         nRST = 1'b0;
  logic         shift_enable = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load = 1'b0;
  logic         serial_out, busy, done;

  int tests = 0;
  int fails = 0;

  // Model: the word last loaded and how many of its bits have been emitted.
  logic         m_loaded = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_k = 0;

  piso_shift_register #(.WIDTH(W)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .shift_enable (shift_enable),
    .data_in      (data_in),
    .load         (load),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e_data;
    logic         e_ser;
    e_data = (m_k >= W) ? '0 : W'(m_word << m_k);
    e_ser  = (m_k < W) ? m_word[W-1-m_k] : 1'b0;
    chk({tag, ".serial_out"}, 32'(serial_out), 32'(e_ser));
    chk({tag, ".busy"}, 32'(busy), 32'(m_loaded && m_k < W));
    chk({tag, ".done"}, 32'(done), 32'(m_loaded && m_k == W));
    chk({tag, ".data"}, 32'(dut.data), 32'(e_data));
    chk({tag, ".count"}, 32'(dut.count), m_loaded ? 32'(W - m_k) : 32'd0);
    $display("[TB] %s: ld=%0b se=%0b din=%02h -> ser=%0b busy=%0b done=%0b data=%02h",
             tag, load, shift_enable, data_in, serial_out, busy, done, dut.data);
  endtask

  task automatic model_reset();
    m_loaded = 1'b0;
    m_word   = '0;
    m_k      = 0;
  endtask

  // One clock edge with the given inputs, then update the model and check.
  task automatic step(input logic ld, input logic se, input logic [W-1:0] din, input string tag);
    load = ld;
    shift_enable = se;
    data_in = din;
    @(posedge clk);
    if (nRST) begin
      if (ld) begin
        m_loaded = 1'b1;
        m_word   = din;
        m_k      = 0;
      end else if (se && m_loaded && m_k < W) begin
        m_k++;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset held for two cycles
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    nRST = 1'b1;

    // Load 8'hB7 on the first edge after release, then idle
    step(1'b1, 1'b0, 8'b1011_0111, "load_b7");
    chk("load_b7.data_const", 32'(dut.data), 32'h0000_00B7);
    step(1'b0, 1'b0, 8'h00, "idle_hold");

    // Eight back-to-back shifts
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 8'h00, $sformatf("shift%0d", i + 1));
    chk("shift_done_const", 32'(done), 32'd1);
    step(1'b0, 1'b0, 8'h00, "post_done_hold");

    // Gapped shifting of 8'hA5
    step(1'b1, 1'b0, 8'hA5, "load_a5");
    for (int i = 0; i < 2 * W; i++)
      step(1'b0, (i % 2 == 0), 8'h00, $sformatf("gap%0d", i));

    // Overrun, reload, and load/shift collision
    step(1'b0, 1'b1, 8'h00, "overrun");
    step(1'b1, 1'b0, 8'h01, "reload_01");
    step(1'b0, 1'b1, 8'h00, "shift_01");
    step(1'b1, 1'b1, 8'h3C, "load_vs_shift");
    chk("load_vs_shift.count_const", 32'(dut.count), 32'd8);

    // Mid-word asynchronous reset after three shifts
    step(1'b1, 1'b0, 8'hFF, "load_ff");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, $sformatf("pre_rst%0d", i));
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    step(1'b0, 1'b1, 8'h00, "reset_held");
    @(negedge clk);
    nRST = 1'b1;
    step(1'b0, 1'b1, 8'h00, "release_no_load");

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, W'($urandom), $sformatf("rnd%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_shift_register.md
# piso_shift_register

Parallel-in serial-out shift register for the bit-level transmit path. It captures a parallel word on `load` and emits it MSB-first on `serial_out`, one bit per clock in which `shift_enable` is asserted. It reports `busy` while bits remain to be shifted and `done` once the word has been fully shifted out. It sits between the byte-level transmit logic and the bit-level encoder and serializer stages.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `clk`  input  1: rising-edge clock.
- `nRST`  input  1: asynchronous, active-low reset.
- `shift_enable`  input  1: advances the register by one bit on this edge when `busy` is high.
- `data_in`  input  WIDTH: parallel word, captured on `load`.
- `load`  input  1: captures `data_in` on this edge.
- `serial_out`  output  1: current MSB of the internal shift register.
- `busy`  output  1: high while unshifted bits remain.
- `done`  output  1: high after the last bit has shifted; sticky until the next `load`.

## Operation
- Internal state:
  - `data[WIDTH-1:0]` is the shift register; the name is fixed for hierarchical probing.
  - `count` is a remaining-bit counter, 0..WIDTH, using the minimum width.
  - `busy`, `done` are registered flags.
- `serial_out = data[WIDTH-1]`, combinational from the register. No extra output flop.
- **Load**, when `load`=1 at an edge:
  - `data` ← `data_in`, `count` ← WIDTH.
  - `busy` ← 1, `done` ← 0.
  - `load` has priority over `shift_enable` on the same edge.
  - A load while busy aborts the current word and restarts with the new one.
- **Shift**, when `load`=0, `shift_enable`=1 and `busy`=1 at an edge:
  - `data` ← {`data[WIDTH-2:0]`, 1'b0}, i.e. shift left with zero fill.
  - `count` ← `count`−1.
  - If `count` was 1: `busy` ← 0 and `done` ← 1 on the same edge.
- **Idle**:
  - `shift_enable`=1 while `busy`=0 is ignored; `data`, `count` and `done` hold.
  - `shift_enable`=0 holds all state. Gaps between shifts are allowed.
- Two-state machine, derived from `busy`:
  - IDLE → LOADED on `load`.
  - LOADED → IDLE on the WIDTH-th shift.
  - `done` distinguishes "never loaded" (0) from "completed" (1).

## Timing
- Reset, asynchronous on `nRST`=0: `data`=0, `count`=0, `busy`=0, `done`=0, therefore `serial_out`=0. State is held while `nRST`=0.
- Release of `nRST` is sampled synchronously. The first active edge with `nRST`=1 may carry `load`.
- Latency:
  - `serial_out` shows `data_in[WIDTH-1]` immediately after the load edge, before any shift.
  - After the k-th shift edge, `serial_out` = `data_in[WIDTH-1-k]` for k < WIDTH, and 0 at k = WIDTH.
- A full word takes exactly WIDTH enabled edges. `done` rises on the WIDTH-th shift edge and `busy` falls on that same edge.
- Reset asserted mid-word clears everything immediately. No `done` is produced for the aborted word.

## Test plan
- **Reset:** hold `nRST`=0 for 2 cycles → `serial_out`=0, `busy`=0, `done`=0, `data`=0.
- **Load:** `data_in`=8'b1011_0111, pulse `load` → next cycle `busy`=1, `done`=0, `serial_out`=1, `data`=8'hB7. It holds through an idle cycle with `shift_enable`=0.
- **Shift out:** from the loaded state, apply 8 consecutive shift edges.
  - `serial_out` after each edge = 0,1,1,0,1,1,1,0.
  - `data` after the 8th edge = 0.
  - After the 8th edge `busy`=0 and `done`=1, and both remain so with `shift_enable`=0.
- **Gapped shift:** toggle `shift_enable` 1/0 while shifting 8'hA5 → bits emitted 1,0,1,0,0,1,0,1 on enabled edges only. `done` rises after the 8th enabled edge.
- **Overrun and reload:**
  - Extra `shift_enable` after `done` → no state change.
  - `load` with 8'h01 → `done`=0, `busy`=1, `serial_out`=0.
  - Assert `load` and `shift_enable` together → load wins and `count` = 8.
- **Mid-word reset:** assert `nRST`=0 asynchronously after 3 shifts → all outputs 0 at once, before the next clock edge. After release with no load, `busy` stays 0.
